// File: rtl/hit_judge_pkg.sv
// Shared constants for the drum hit judge: grade codes, FSM state encoding, slot count.
package hit_judge_pkg;

  localparam int unsigned NUM_SLOTS = 15;
  localparam int unsigned X_W       = 8;
  localparam int unsigned DIST_W    = 9;
  localparam int unsigned IDX_W     = 4;

  localparam logic [1:0] GRADE_NONE  = 2'b00;
  localparam logic [1:0] GRADE_GREAT = 2'b01;
  localparam logic [1:0] GRADE_GOOD  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_JUDGE    = 3'd2,
    ST_HOLD     = 3'd3,
    ST_RELEASE  = 3'd4
  } state_e;

  // Unsigned distance between two x coordinates, widened so it never wraps.
  function automatic logic [DIST_W-1:0] abs_dist(input logic [X_W-1:0] a,
                                                 input logic [X_W-1:0] b);
    return (a >= b) ? DIST_W'(a - b) : DIST_W'(b - a);
  endfunction

endpackage

// File: rtl/hit_judge_key_debouncer.sv
// Drum key synchronizer plus run-length counter of consecutive equal samples.
module key_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic key_sync,
  output logic key_hi_stable_c,
  output logic key_lo_stable_c
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // cnt_q counts how many consecutive synchronized samples equalled last_q, saturating.
  always_comb begin
    sync1_d = key_raw;
    sync2_d = sync1_q;
    last_d  = sync2_q;
    cnt_d   = cnt_q;
    if (sync2_q != last_q) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign key_sync        = sync2_q;
  assign key_hi_stable_c = last_q  && (cnt_q == CNT_MAX);
  assign key_lo_stable_c = !last_q && (cnt_q == CNT_MAX);

endmodule

// File: rtl/hit_judge.sv
// Drum hit judge: debounces the drum key, scans 15 note slots and grades the closest one.
// Optional miss detection is enabled by defining HIT_JUDGE_MISS_EN.
module hit_judge
  import hit_judge_pkg::*;
#(
  parameter logic [7:0]  HIT_X           = 8'd40,
  parameter int unsigned GREAT_WIN       = 3,
  parameter int unsigned GOOD_WIN        = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned HOLD_CYCLES     = 1000
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  input  logic         drum_key,
  input  logic [14:0]  note_active,
  input  logic [119:0] note_x,
  output logic [29:0]  judge_out,
  output logic [14:0]  note_clear,
  output logic         miss_pulse
);

  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0]  SCAN_LAST = IDX_W'(NUM_SLOTS - 1);

  logic key_sync, key_hi_stable_c, key_lo_stable_c;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debouncer (
    .clk             (CLOCK_50),
    .rst             (reset),
    .key_raw         (drum_key),
    .key_sync        (key_sync),
    .key_hi_stable_c (key_hi_stable_c),
    .key_lo_stable_c (key_lo_stable_c)
  );

  logic [X_W-1:0] slot_x [NUM_SLOTS];

  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      slot_x[i] = note_x[X_W*i +: X_W];
    end
  end

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      scan_q, scan_d;
  logic [IDX_W-1:0]      best_idx_q, best_idx_d;
  logic [DIST_W-1:0]     best_dist_q, best_dist_d;
  logic                  best_valid_q, best_valid_d;
  logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
  logic [2*NUM_SLOTS-1:0] judge_out_q, judge_out_d;
  logic [NUM_SLOTS-1:0]  note_clear_q, note_clear_d;

  logic [DIST_W-1:0] cur_dist_c;
  logic              slot_missed_c;
  logic              cand_c;
  logic              better_c;
  logic [1:0]        grade_c;

`ifdef HIT_JUDGE_MISS_EN
  localparam int unsigned MISS_TH_I = (32'(HIT_X) > GOOD_WIN) ? (32'(HIT_X) - GOOD_WIN) : 0;
  localparam logic [X_W-1:0] MISS_TH = X_W'(MISS_TH_I);

  logic [NUM_SLOTS-1:0] missed_q, missed_d;
  logic                 miss_pulse_q, miss_pulse_d;

  // A flag sticks while the note stays active; the note being shown in HOLD is exempt.
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      missed_d[i] = note_active[i] &&
                    (missed_q[i] ||
                     ((slot_x[i] < MISS_TH) &&
                      !((state_q == ST_HOLD) && (best_idx_q == IDX_W'(i)))));
    end
    miss_pulse_d = |(missed_d & ~missed_q);
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      missed_q     <= '0;
      miss_pulse_q <= 1'b0;
    end else begin
      missed_q     <= missed_d;
      miss_pulse_q <= miss_pulse_d;
    end
  end

  assign slot_missed_c = missed_q[scan_q];
  assign miss_pulse    = miss_pulse_q;
`else
  assign slot_missed_c = 1'b0;
  assign miss_pulse    = 1'b0;
`endif

  // Ascending scan with strict less-than keeps the lowest index on ties.
  assign cur_dist_c = abs_dist(slot_x[scan_q], HIT_X);
  assign cand_c     = note_active[scan_q] && (cur_dist_c <= DIST_W'(GOOD_WIN)) && !slot_missed_c;
  assign better_c   = cand_c && (!best_valid_q || (cur_dist_c < best_dist_q));

  always_comb begin
    state_d      = state_q;
    scan_d       = scan_q;
    best_idx_d   = best_idx_q;
    best_dist_d  = best_dist_q;
    best_valid_d = best_valid_q;
    hold_cnt_d   = hold_cnt_q;
    judge_out_d  = judge_out_q;
    note_clear_d = '0;
    grade_c      = GRADE_NONE;

    unique case (state_q)
      ST_IDLE: begin
        if (key_sync) state_d = ST_DEBOUNCE;
      end
      ST_DEBOUNCE: begin
        if (!key_sync) begin
          state_d = ST_IDLE;
        end else if (key_hi_stable_c) begin
          state_d      = ST_JUDGE;
          scan_d       = '0;
          best_valid_d = 1'b0;
        end
      end
      ST_JUDGE: begin
        if (better_c) begin
          best_idx_d   = scan_q;
          best_dist_d  = cur_dist_c;
          best_valid_d = 1'b1;
        end
        if (scan_q == SCAN_LAST) begin
          if (best_valid_d) begin
            state_d    = ST_HOLD;
            hold_cnt_d = '0;
            grade_c    = (best_dist_d <= DIST_W'(GREAT_WIN)) ? GRADE_GREAT : GRADE_GOOD;
            judge_out_d = '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
              if (best_idx_d == IDX_W'(i)) judge_out_d[2*i +: 2] = grade_c;
            end
            note_clear_d[best_idx_d] = 1'b1;
          end else begin
            state_d = ST_RELEASE;
          end
        end else begin
          scan_d = scan_q + IDX_W'(1);
        end
      end
      ST_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d     = ST_RELEASE;
          judge_out_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      ST_RELEASE: begin
        if (key_lo_stable_c) state_d = ST_IDLE;
      end
      default: begin
        state_d     = ST_IDLE;
        judge_out_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      scan_q       <= '0;
      best_idx_q   <= '0;
      best_dist_q  <= '0;
      best_valid_q <= 1'b0;
      hold_cnt_q   <= '0;
      judge_out_q  <= '0;
      note_clear_q <= '0;
    end else begin
      state_q      <= state_d;
      scan_q       <= scan_d;
      best_idx_q   <= best_idx_d;
      best_dist_q  <= best_dist_d;
      best_valid_q <= best_valid_d;
      hold_cnt_q   <= hold_cnt_d;
      judge_out_q  <= judge_out_d;
      note_clear_q <= note_clear_d;
    end
  end

  assign judge_out  = judge_out_q;
  assign note_clear = note_clear_q;

endmodule

// File: tb/tb_hit_judge.sv
// Self-checking bench for hit_judge: directed scenarios plus randomized note fields
// checked against a closest-note reference model.
module tb_hit_judge;

  logic         clk = 1'b0;
  logic         rst;
  logic         drum_key;
  logic [14:0]  note_active;
  logic [119:0] note_x;
  logic [29:0]  judge_out;
  logic [14:0]  note_clear;
  logic         miss_pulse;

  always #5 clk = ~clk;

  hit_judge #(
    .HIT_X(8'd40), .GREAT_WIN(3), .GOOD_WIN(8), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(4)
  ) dut (
    .CLOCK_50   (clk),
    .reset      (rst),
    .drum_key   (drum_key),
    .note_active(note_active),
    .note_x     (note_x),
    .judge_out  (judge_out),
    .note_clear (note_clear),
    .miss_pulse (miss_pulse)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Observation counters for the current window.
  int          judge_events, jo_cycles, clr_cnt, clr_at, multi_err, bad_grade, miss_cnt;
  int          seen_slot, seen_grade;
  logic [14:0] clr_vec;
  bit          prev_nz;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    judge_events = 0; jo_cycles = 0; clr_cnt = 0; clr_at = 0;
    multi_err = 0; bad_grade = 0; miss_cnt = 0;
    seen_slot = -1; seen_grade = 0; clr_vec = '0; prev_nz = 1'b0;
  endtask

  // Advance to the next falling edge and record what the outputs show.
  task automatic step();
    int nz;
    @(negedge clk);
    nz = 0;
    for (int i = 0; i < 15; i++) begin
      if (judge_out[2*i +: 2] != 2'b00) begin
        nz++;
        seen_slot  = i;
        seen_grade = int'(judge_out[2*i +: 2]);
        if (judge_out[2*i +: 2] == 2'b11) bad_grade++;
      end
    end
    if (nz > 1) multi_err++;
    if (nz != 0) jo_cycles++;
    if (nz != 0 && !prev_nz) judge_events++;
    prev_nz = (nz != 0);
    if (note_clear != '0) begin
      clr_cnt++;
      clr_vec = note_clear;
      clr_at  = jo_cycles;
    end
    if (miss_pulse) miss_cnt++;
  endtask

  task automatic clear_notes();
    note_active = '0;
    note_x      = '0;
  endtask

  task automatic set_note(input int s, input int x);
    note_x[8*s +: 8] = 8'(x);
    note_active[s]   = 1'b1;
  endtask

  task automatic press(input int hi, input int lo);
    drum_key = 1'b1;
    repeat (hi) step();
    drum_key = 1'b0;
    repeat (lo) step();
  endtask

  task automatic wait_judge(input string tag);
    int n = 0;
    while (judge_out == '0 && n < 60) begin
      step();
      n++;
    end
    check_eq({tag, "_seen"}, 32'(judge_out != '0), 32'd1);
  endtask

  task automatic expect_judge(input string tag, input int slot, input int grade);
    check_eq({tag, "_events"}, 32'(judge_events), (slot < 0) ? 32'd0 : 32'd1);
    if (slot >= 0) begin
      check_eq({tag, "_slot"},   32'(seen_slot),  32'(slot));
      check_eq({tag, "_grade"},  32'(seen_grade), 32'(grade));
      check_eq({tag, "_hold"},   32'(jo_cycles),  32'd4);
      check_eq({tag, "_clrcnt"}, 32'(clr_cnt),    32'd1);
      check_eq({tag, "_clrvec"}, 32'(clr_vec),    32'd1 << slot);
      check_eq({tag, "_clrat"},  32'(clr_at),     32'd1);
    end else begin
      check_eq({tag, "_noclr"}, 32'(clr_cnt), 32'd0);
    end
    check_eq({tag, "_onehot"}, 32'(multi_err + bad_grade), 32'd0);
  endtask

  // Closest active note within the good window wins; earliest slot on a tie.
  function automatic void model(input logic [14:0] act, input logic [119:0] xs,
                                output int slot, output int grade);
    int best_d;
    slot   = -1;
    best_d = 1000;
    for (int i = 0; i < 15; i++) begin
      if (act[i]) begin
        int x;
        int d;
        x = int'(xs[8*i +: 8]);
        d = (x > 40) ? (x - 40) : (40 - x);
        if (d <= 8 && d < best_d) begin
          best_d = d;
          slot   = i;
        end
      end
    end
    grade = (slot < 0) ? 0 : ((best_d <= 3) ? 1 : 2);
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, %0d checks", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int es, eg;
    rst = 1'b1;
    drum_key = 1'b0;
    clear_notes();
    clear_mon();
    repeat (3) step();
    check_eq("rst_judge_out",  32'(judge_out),  32'd0);
    check_eq("rst_note_clear", 32'(note_clear), 32'd0);
    check_eq("rst_miss_pulse", 32'(miss_pulse), 32'd0);
    rst = 1'b0;
    repeat (8) step();

    clear_mon(); set_note(3, 41); press(30, 20);
    expect_judge("single_great", 3, 1);

    clear_notes(); set_note(0, 46); set_note(5, 34);
    clear_mon(); press(30, 20);
    expect_judge("tie_low_index", 0, 2);

    clear_notes(); set_note(7, 40);
    clear_mon(); press(2, 20);
    expect_judge("short_press", -1, 0);
    clear_mon(); press(30, 20);
    expect_judge("after_short", 7, 1);

    clear_notes(); set_note(1, 49); set_note(2, 60);
    clear_mon(); press(30, 20);
    expect_judge("no_candidate", -1, 0);
    set_note(9, 48);
    clear_mon(); press(30, 20);
    expect_judge("edge_good", 9, 2);

    clear_notes(); set_note(4, 43); set_note(11, 36);
    clear_mon(); press(30, 20);
    expect_judge("edge_great", 4, 1);

    // Long hold gives one judgement; a re-press after 4 low cycles gives another.
    clear_notes(); set_note(6, 38);
    clear_mon();
    drum_key = 1'b1; repeat (100) step();
    check_eq("long_hold_events", 32'(judge_events), 32'd1);
    drum_key = 1'b0; repeat (4) step();
    drum_key = 1'b1; repeat (40) step();
    drum_key = 1'b0; repeat (20) step();
    check_eq("repress_events", 32'(judge_events), 32'd2);

    clear_notes(); set_note(3, 41);
    clear_mon();
    drum_key = 1'b1;
    wait_judge("drop_hold");
    note_active = '0;
    repeat (25) step();
    drum_key = 1'b0;
    repeat (20) step();
    expect_judge("drop_in_hold", 3, 1);

    clear_notes(); set_note(3, 41);
    clear_mon();
    drum_key = 1'b1;
    wait_judge("rst_hold");
    rst = 1'b1;
    drum_key = 1'b0;
    #1;
    check_eq("rst_hold_judge_out",  32'(judge_out),  32'd0);
    check_eq("rst_hold_note_clear", 32'(note_clear), 32'd0);
    repeat (2) step();
    rst = 1'b0;
    clear_mon();
    repeat (30) step();
    check_eq("post_rst_events", 32'(judge_events), 32'd0);
    check_eq("post_rst_clr",    32'(clr_cnt),      32'd0);
    clear_mon(); press(30, 20);
    expect_judge("after_reset", 3, 1);

    // Slot 2 passes the hit line, then comes back into the window while still active.
    clear_notes(); repeat (3) step();
    clear_mon();
    set_note(2, 33); repeat (5) step();
    note_x[23:16] = 8'd31; repeat (5) step();
    note_x[23:16] = 8'd36; repeat (3) step();
`ifdef HIT_JUDGE_MISS_EN
    check_eq("miss_single", 32'(miss_cnt), 32'd1);
    clear_mon(); press(30, 20);
    expect_judge("missed_not_graded", -1, 0);
    set_note(4, 33); set_note(6, 35); repeat (3) step();
    note_x[39:32] = 8'd20; note_x[55:48] = 8'd20; repeat (5) step();
    check_eq("miss_simultaneous", 32'(miss_cnt), 32'd1);
    clear_notes(); repeat (3) step();
    set_note(2, 36);
    clear_mon(); press(30, 20);
    expect_judge("miss_cleared", 2, 2);
`else
    check_eq("miss_off_pulse", 32'(miss_cnt), 32'd0);
    clear_mon(); press(30, 20);
    expect_judge("miss_off_graded", 2, 2);
    check_eq("miss_off_pulse2", 32'(miss_cnt), 32'd0);
`endif

    for (int t = 0; t < 12; t++) begin
      clear_notes(); repeat (2) step();
      note_active = 15'($urandom) & 15'($urandom);
      for (int s = 0; s < 15; s++) note_x[8*s +: 8] = 8'($urandom_range(32, 60));
      model(note_active, note_x, es, eg);
      clear_mon();
      press(int'($urandom_range(8, 40)), 20);
      expect_judge($sformatf("rand%0d", t), es, eg);
      check_eq($sformatf("rand%0d_miss", t), 32'(miss_cnt), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hit_judge.md
HIT_JUDGE -- requirements
Module: hit_judge

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- HIT_X, 8'd40, x coordinate of the drum hit line.
- GREAT_WIN, 3, max |note_x-HIT_X| graded great.
- GOOD_WIN, 8, max |note_x-HIT_X| graded good; SHALL be >= GREAT_WIN.
- DEBOUNCE_CYCLES, 250000, consecutive stable samples required on drum_key.
- HOLD_CYCLES, 1000, cycles a grade is held on judge_out.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- CLOCK_50, in, 1, sole clock.
- reset, in, 1, asynchronous active-high reset.
- drum_key, in, 1, raw drum button, active-high, asynchronous to the clock.
- note_active, in, 15, per-slot note present.
- note_x, in, 120, packed slot x; slot i occupies bits [8i+7:8i].
- judge_out, out, 30, per-slot grade; bits [2i+1:2i] feed signal(i+1) of the scoreboard.
- note_clear, out, 15, one-cycle pulse removing the judged note.
- miss_pulse, out, 1, one-cycle pulse per missed note.

Function
REQ-003 Grade encoding SHALL be 2'b01 great (+2 points), 2'b10 good (+1 point), 2'b00 none; 2'b11 SHALL never be driven.
REQ-004 drum_key SHALL pass through a 2-flop synchronizer before any use.
REQ-005 The FSM SHALL have the states IDLE, DEBOUNCE, JUDGE, HOLD and RELEASE.
REQ-006 IDLE -> DEBOUNCE SHALL occur when the synchronized key is 1.
REQ-007 DEBOUNCE SHALL return to IDLE if the key drops before DEBOUNCE_CYCLES consecutive high samples, and SHALL go to JUDGE when that count is reached.
REQ-008 JUDGE SHALL scan slots 0..14, one slot per cycle, over exactly 15 cycles; distance is a 9-bit unsigned |note_x-HIT_X|.
REQ-009 A slot SHALL be a candidate only if it is active, its distance is <= GOOD_WIN, and its missed flag is clear.
REQ-010 The best candidate SHALL be the one with the smallest distance; ties go to the lowest index.
REQ-011 After the scan, FSM SHALL go to HOLD if a candidate exists, otherwise to RELEASE with no output.
REQ-012 On HOLD entry:
- judge_out[best] SHALL take the grade (great if distance <= GREAT_WIN, else good) for exactly HOLD_CYCLES cycles, with all other slots at 00.
- note_clear[best] SHALL pulse for the first cycle of HOLD only.
REQ-013 HOLD SHALL then go to RELEASE, and judge_out SHALL return to 0.
REQ-014 RELEASE SHALL wait for DEBOUNCE_CYCLES consecutive low samples, then go to IDLE; key presses in JUDGE, HOLD and RELEASE SHALL be ignored.
REQ-015 A note_active drop during JUDGE or HOLD SHALL NOT alter the latched grade or slot.
REQ-016 At most one judge_out slot SHALL be nonzero in any cycle.

Reset
REQ-017 Reset SHALL force:
- state IDLE;
- all counters and missed flags to 0;
- judge_out = 0, note_clear = 0, miss_pulse = 0;
- synchronizer flops to 0.
REQ-018 Reset asserted mid-HOLD SHALL clear judge_out asynchronously, with no pending pulse after release.

Configuration
REQ-019 Macro HIT_JUDGE_MISS_EN SHALL control miss detection.
REQ-020 With the macro defined:
- The per-slot missed flag SHALL set when the slot is active, note_x < HIT_X-GOOD_WIN (saturating at 0), and the slot is not currently selected in HOLD.
- miss_pulse SHALL pulse once per flag 0->1 transition.
- A flag SHALL clear when note_active[i] falls.
- Simultaneous new misses SHALL produce a single pulse, and all flags SHALL set.
REQ-021 Without the macro, miss_pulse SHALL be constant 0, no missed-flag logic SHALL exist, and REQ-009 SHALL ignore missed flags.

Structure
REQ-022 The shared package SHALL hold the grade constants (GRADE_NONE/GREAT/GOOD), the FSM state encoding, and NUM_SLOTS=15.
REQ-023 Sub-module key_debouncer (synchronizer plus stable counter) SHALL be instantiated once.

Verification
All scenarios use bench parameters HIT_X=40, GREAT_WIN=3, GOOD_WIN=8, DEBOUNCE_CYCLES=4, HOLD_CYCLES=4.
REQ-024 Slot 3 at x=41 active, key held 30 cycles -> judge_out[7:6]=01 for 4 cycles, note_clear[3] pulses once, all other bits 0.
REQ-025 Slot 0 x=46, slot 5 x=34 (tie at distance 6) -> slot 0 graded 10, slot 5 untouched.
REQ-026 Key high 2 cycles then low -> FSM returns to IDLE, judge_out stays 0; no active slot within 8 -> no output, FSM goes to RELEASE.
REQ-027 Key held continuously 100 cycles -> exactly one judgement; re-press after 4 low cycles -> second judgement.
REQ-028 Reset pulse during HOLD -> judge_out=0 in the same cycle; after reset, outputs stay 0 until a new press.
REQ-029 With HIT_JUDGE_MISS_EN, slot 2 moves 33->31 -> one miss_pulse, and a later press does not grade slot 2; without the macro, miss_pulse stays 0.
